p_mul_unit: RTL

P_MUL_UNIT -- requirements
Module: p_mul_unit

---
 rtl/p_mul_unit.sv | 95 +++++++++
 1 files changed

// File: rtl/p_mul_unit.sv
// rtl/p_mul_unit.sv - packed SIMD multiplier (2x16 or 4x8 lanes), one lane per cycle
module p_mul_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_e,
    input  logic [5:0]  alu_control_e,
    input  logic [31:0] src_a_e,
    input  logic [31:0] src_b_e,
    input  logic        flush_e,
    output logic        stall_mul_e,
    output logic        done_e,
    output logic [31:0] result_lo_e,
    output logic [31:0] result_hi_e
);
    localparam logic [5:0] SMUL16 = 6'b100010;
    localparam logic [5:0] UMUL16 = 6'b100011;
    localparam logic [5:0] SMUL8  = 6'b100100;
    localparam logic [5:0] UMUL8  = 6'b100101;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_next;
    logic [1:0]  cnt;
    logic [31:0] a_q, b_q;
    logic [5:0]  code_q;
    logic [63:0] prod;

    logic        is_mul, accept, is16_q, sgn_q, last_lane;
    logic [15:0] a16, b16;
    logic [7:0]  a8, b8;
    logic [31:0] ea16, eb16, p16;
    logic [15:0] ea8, eb8, p8;

    assign is_mul = (alu_control_e == SMUL16) || (alu_control_e == UMUL16) ||
                    (alu_control_e == SMUL8)  || (alu_control_e == UMUL8);
    assign accept = (state == IDLE) && start_e && is_mul && !flush_e;

    assign is16_q    = (code_q == SMUL16) || (code_q == UMUL16);
    assign sgn_q     = (code_q == SMUL16) || (code_q == SMUL8);
    assign last_lane = is16_q ? (cnt == 2'd1) : (cnt == 2'd3);

    // Products are taken modulo the lane width, so extending to that width
    // before an unsigned multiply gives the correct signed result too.
    assign a16  = cnt[0] ? a_q[31:16] : a_q[15:0];
    assign b16  = cnt[0] ? b_q[31:16] : b_q[15:0];
    assign ea16 = {{16{sgn_q & a16[15]}}, a16};
    assign eb16 = {{16{sgn_q & b16[15]}}, b16};
    assign p16  = ea16 * eb16;

    assign a8  = a_q[{cnt, 3'b000} +: 8];
    assign b8  = b_q[{cnt, 3'b000} +: 8];
    assign ea8 = {{8{sgn_q & a8[7]}}, a8};
    assign eb8 = {{8{sgn_q & b8[7]}}, b8};
    assign p8  = ea8 * eb8;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (last_lane) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush_e) state_next = IDLE;
    end

    assign stall_mul_e = !reset && (accept || ((state == CALC) && !flush_e));
    assign done_e      = !reset && !flush_e && (state == DONE);
    assign result_lo_e = prod[31:0];
    assign result_hi_e = prod[63:32];

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 2'd0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            code_q <= 6'd0;
            prod   <= 64'd0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_q    <= src_a_e;
                b_q    <= src_b_e;
                code_q <= alu_control_e;
                cnt    <= 2'd0;
                prod   <= 64'd0;
            end else if ((state == CALC) && !flush_e) begin
                if (is16_q) prod[{cnt[0], 5'b00000} +: 32] <= p16;
                else        prod[{cnt, 4'b0000} +: 16]     <= p8;
                cnt <= cnt + 2'd1;
            end
        end
    end
endmodule
